rv32_mem: RTL and testbench

Unified instruction/data memory responder for the single-clock RV32 core. It answers the core's instruction-fetch port and data-memory port from one word-organised RAM, with combinational reads and synchronous writes. A byte-serial program loader fills the RAM after reset or on request, and holds the core in reset through its `cpu_rst_o` output until loading ends.

---
 rtl/rv32_mem.sv | 171 +++++++++++++++++
 tb/tb_rv32_mem.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem.sv
// Unified instruction/data RAM for the single-clock RV32 core, filled by a byte-serial loader.
// Latency: reads are combinational (0 cycles); writes land on the rising edge and are readable the next cycle.
// Backpressure: none; loader bytes beyond RAM capacity are dropped and flagged, and data writes are ignored while loading.
module rv32_mem #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [XLEN-1:0]       instr_iaddr_i,
    output logic [XLEN-1:0]       instr_data_o,
    input  logic                  mem_we_i,
    input  logic [XLEN-1:0]       mem_addr_i,
    input  logic [XLEN-1:0]       mem_data_i,
    output logic [XLEN-1:0]       mem_data_o,
    input  logic                  load_start_i,
    input  logic                  load_valid_i,
    input  logic [7:0]            load_data_i,
    input  logic                  load_end_i,
    output logic                  cpu_rst_o,
    output logic                  load_busy_o,
    output logic [DEPTH_LOG2:0]   load_words_o,
    output logic                  load_ovf_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    // Word storage; deliberately not reset so a reset mid-load keeps what was already loaded.
    logic [XLEN-1:0] ram [DEPTH];

    // Loader assembly: only lanes 0..2 need storage, lane 3 always comes straight from the
    // incoming byte on the cycle a full word completes. Unfilled lanes stay zero, which gives
    // the zero-filled partial word on load_end for free.
    logic [1:0]  byte_cnt;
    logic [23:0] asm_lo;

    // Next-state helpers for the loader.
    logic        take;
    logic        ovf_hit;
    logic [2:0]  cnt_next;
    logic [23:0] asm_next;
    logic [7:0]  lane3;
    logic [31:0] ld_word;
    logic        ld_we;
    logic        run_we;
    logic        ram_full;

    // Word indices for the two read ports (byte offset and high bits dropped, so addresses wrap).
    logic [DEPTH_LOG2-1:0] iidx;
    logic [DEPTH_LOG2-1:0] didx;
    logic [DEPTH_LOG2-1:0] waddr;

    assign iidx  = instr_iaddr_i[DEPTH_LOG2+1:2];
    assign didx  = mem_addr_i[DEPTH_LOG2+1:2];
    assign waddr = load_words_o[DEPTH_LOG2-1:0];

    // The write pointer never wraps: once the count reaches DEPTH the top bit marks the RAM full.
    assign ram_full = load_words_o[DEPTH_LOG2];

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_iaddr_i[XLEN-1:DEPTH_LOG2+2], instr_iaddr_i[1:0],
                                mem_addr_i[XLEN-1:DEPTH_LOG2+2], mem_addr_i[1:0]};

    // Loader datapath: absorb this cycle's byte, then decide whether a full or partial word is written.
    always_comb begin
        take     = 1'b0;
        ovf_hit  = 1'b0;
        cnt_next = {1'b0, byte_cnt};
        asm_next = asm_lo;
        lane3    = 8'h00;
        ld_we    = 1'b0;
        if (state == LOAD && !load_start_i) begin
            if (load_valid_i) begin
                if (ram_full) begin
                    ovf_hit = 1'b1;
                end else begin
                    take     = 1'b1;
                    cnt_next = {1'b0, byte_cnt} + 3'd1;
                    case (byte_cnt)
                        2'd0:    asm_next[7:0]   = load_data_i;
                        2'd1:    asm_next[15:8]  = load_data_i;
                        2'd2:    asm_next[23:16] = load_data_i;
                        default: lane3           = load_data_i;
                    endcase
                end
            end
            // A full word, or any partial word left over when loading ends, is committed this edge.
            ld_we = (cnt_next == 3'd4) || (load_end_i && cnt_next != 3'd0);
        end
    end

    assign ld_word = {lane3, asm_next};

    // Core data writes only count in RUN, and a reload request in the same cycle wins.
    assign run_we = (state == RUN) && mem_we_i && !load_start_i;

    // RAM write port; loader and core writes are exclusive by state, and nothing lands while reset is held.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (ld_we) begin
                ram[waddr] <= ld_word;
            end else if (run_we) begin
                ram[didx] <= mem_data_i;
            end
        end
    end

    // Combinational read ports, valid in every state.
    assign instr_data_o = ram[iidx];
    assign mem_data_o   = ram[didx];

    // Load/run controller with registered core reset, busy flag, word count and overflow flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= LOAD;
            byte_cnt     <= 2'd0;
            asm_lo       <= 24'h0;
            load_words_o <= '0;
            load_ovf_o   <= 1'b0;
            cpu_rst_o    <= 1'b1;
            load_busy_o  <= 1'b1;
        end else if (state == LOAD) begin
            if (load_start_i) begin
                // Restart: throw away everything counted so far, keep the core held.
                byte_cnt     <= 2'd0;
                asm_lo       <= 24'h0;
                load_words_o <= '0;
                load_ovf_o   <= 1'b0;
            end else begin
                if (ld_we) begin
                    load_words_o <= load_words_o + 1'b1;
                    byte_cnt     <= 2'd0;
                    asm_lo       <= 24'h0;
                end else if (take) begin
                    byte_cnt <= cnt_next[1:0];
                    asm_lo   <= asm_next;
                end
                if (ovf_hit) begin
                    load_ovf_o <= 1'b1;
                end
                if (load_end_i) begin
                    // Release the core on this edge; it fetches address 0 next cycle.
                    state       <= RUN;
                    byte_cnt    <= 2'd0;
                    asm_lo      <= 24'h0;
                    cpu_rst_o   <= 1'b0;
                    load_busy_o <= 1'b0;
                end
            end
        end else begin
            if (load_start_i) begin
                state        <= LOAD;
                byte_cnt     <= 2'd0;
                asm_lo       <= 24'h0;
                load_words_o <= '0;
                load_ovf_o   <= 1'b0;
                cpu_rst_o    <= 1'b1;
                load_busy_o  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32_mem.sv
// Bench for rv32_mem: two instances (1024 and 4 words) share one stimulus stream.
// Latency: expectations are queued per cycle and compared on the falling edge of that cycle.
// Backpressure: none; the reference model tracks loaded bytes and written words directly.
module tb_rv32_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] iaddr;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic        mwe;
    logic        lstart;
    logic        lvalid;
    logic [7:0]  ldata;
    logic        lend;

    logic [31:0] b_instr, b_mdata, s_instr, s_mdata;
    logic        b_cpu_rst, b_busy, b_ovf, s_cpu_rst, s_busy, s_ovf;
    logic [10:0] b_words;
    logic [2:0]  s_words;

    rv32_mem #(.XLEN(32), .DEPTH_LOG2(10)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_iaddr_i(iaddr), .instr_data_o(b_instr),
        .mem_we_i(mwe), .mem_addr_i(maddr), .mem_data_i(mdata), .mem_data_o(b_mdata),
        .load_start_i(lstart), .load_valid_i(lvalid), .load_data_i(ldata), .load_end_i(lend),
        .cpu_rst_o(b_cpu_rst), .load_busy_o(b_busy), .load_words_o(b_words), .load_ovf_o(b_ovf)
    );

    rv32_mem #(.XLEN(32), .DEPTH_LOG2(2)) dut_s (
        .clk_i(clk), .rst_i(rst),
        .instr_iaddr_i(iaddr), .instr_data_o(s_instr),
        .mem_we_i(mwe), .mem_addr_i(maddr), .mem_data_i(mdata), .mem_data_o(s_mdata),
        .load_start_i(lstart), .load_valid_i(lvalid), .load_data_i(ldata), .load_end_i(lend),
        .cpu_rst_o(s_cpu_rst), .load_busy_o(s_busy), .load_words_o(s_words), .load_ovf_o(s_ovf)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t sbq[$];

    string names [12] = '{"big.instr_data", "big.mem_data", "big.cpu_rst", "big.load_busy",
                          "big.load_words", "big.load_ovf", "small.instr_data", "small.mem_data",
                          "small.cpu_rst", "small.load_busy", "small.load_words", "small.load_ovf"};

    function automatic logic [31:0] sample(int sel);
        case (sel)
            0:       return b_instr;
            1:       return b_mdata;
            2:       return {31'b0, b_cpu_rst};
            3:       return {31'b0, b_busy};
            4:       return {21'b0, b_words};
            5:       return {31'b0, b_ovf};
            6:       return s_instr;
            7:       return s_mdata;
            8:       return {31'b0, s_cpu_rst};
            9:       return {31'b0, s_busy};
            10:      return {29'b0, s_words};
            default: return {31'b0, s_ovf};
        endcase
    endfunction

    // Reference model: the loader is a list of accepted bytes; words are slices of that list.
    int          m_depth   [2] = '{1024, 4};
    logic [31:0] m_mem     [2][1024];
    bit          m_known   [2][1024];
    logic [7:0]  m_bytes   [2][4096];
    int          m_nb      [2];
    bit          m_ovf     [2];
    bit          m_loading [2];

    function automatic void m_reset(int m);
        m_nb[m]      = 0;
        m_ovf[m]     = 1'b0;
        m_loading[m] = 1'b1;
    endfunction

    function automatic int m_words(int m);
        if (m_loading[m]) return m_nb[m] / 4;
        return (m_nb[m] + 3) / 4;
    endfunction

    function automatic void m_commit(int m, int w);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < 4; k++)
            if (4 * w + k < m_nb[m]) v[8*k +: 8] = m_bytes[m][4*w+k];
        m_mem[m][w]   = v;
        m_known[m][w] = 1'b1;
    endfunction

    // Effect of the current inputs at the coming rising edge.
    function automatic void m_edge(int m);
        int di;
        if (lstart) begin
            m_reset(m);
        end else if (m_loading[m]) begin
            if (lvalid) begin
                if (m_nb[m] < 4 * m_depth[m]) begin
                    m_bytes[m][m_nb[m]] = ldata;
                    m_nb[m]++;
                    if (m_nb[m] % 4 == 0) m_commit(m, m_nb[m] / 4 - 1);
                end else begin
                    m_ovf[m] = 1'b1;
                end
            end
            if (lend) begin
                if (m_nb[m] % 4 != 0) m_commit(m, m_nb[m] / 4);
                m_loading[m] = 1'b0;
            end
        end else if (mwe) begin
            di = int'(maddr[31:2]) & (m_depth[m] - 1);
            m_mem[m][di]   = mdata;
            m_known[m][di] = 1'b1;
        end
    endfunction

    task automatic push(int sel, logic [31:0] v);
        sbq.push_back('{cyc, sel, v});
    endtask

    // Queue this cycle's expectations from the model, advance the model, move to the next cycle.
    task automatic step();
        int b, ii, di;
        for (int m = 0; m < 2; m++) begin
            if (rst) m_reset(m);
            b = 6 * m;
            push(b + 2, {31'b0, m_loading[m]});
            push(b + 3, {31'b0, m_loading[m]});
            push(b + 4, 32'(m_words(m)));
            push(b + 5, {31'b0, m_ovf[m]});
            ii = int'(iaddr[31:2]) & (m_depth[m] - 1);
            di = int'(maddr[31:2]) & (m_depth[m] - 1);
            if (m_known[m][ii]) push(b + 0, m_mem[m][ii]);
            if (m_known[m][di]) push(b + 1, m_mem[m][di]);
        end
        if (!rst) for (int m = 0; m < 2; m++) m_edge(m);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bus();
        iaddr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        maddr = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
        mdata = $urandom;
        mwe   = 1'($urandom_range(0, 1));
    endtask

    // Monitor: compare every expectation queued for the current cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                vectors++;
                if (e.cyc != cyc) begin
                    miscompares++;
                    $display("FAIL stale %s: queued for cycle %0d, seen at cycle %0d", names[e.sel], e.cyc, cyc);
                end else begin
                    act = sample(e.sel);
                    if (act !== e.exp) begin
                        miscompares++;
                        $display("FAIL %s cycle %0d: got %h want %h", names[e.sel], cyc, act, e.exp);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0]  seq [8];
        logic [31:0] w;
        int          n;

        rst = 1'b1; iaddr = '0; maddr = '0; mdata = '0; mwe = 1'b0;
        lstart = 1'b0; lvalid = 1'b0; ldata = '0; lend = 1'b0;
        for (int m = 0; m < 2; m++) m_reset(m);
        @(posedge clk);
        #1;

        // Reset state
        push(2, 32'h1); push(3, 32'h1); push(4, 32'h0); push(5, 32'h0);
        push(8, 32'h1); push(9, 32'h1); push(10, 32'h0); push(11, 32'h0);
        step();
        rst = 1'b0;

        // Full-word load of two instructions
        seq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 8; i++) begin
            lvalid = 1'b1; ldata = seq[i];
            step();
        end
        lvalid = 1'b0; lend = 1'b1;
        push(2, 32'h1);
        step();
        lend = 1'b0;
        iaddr = 32'h4; maddr = 32'h0;
        push(0, 32'h0010_0093); push(1, 32'h0000_0013); push(2, 32'h0); push(4, 32'h2);
        push(6, 32'h0010_0093); push(10, 32'h2);
        step();

        // Partial flush: last byte arrives together with load_end
        lstart = 1'b1;
        step();
        lstart = 1'b0;
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAB, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            lvalid = 1'b1; ldata = seq[i];
            step();
        end
        ldata = seq[4]; lend = 1'b1;
        step();
        lvalid = 1'b0; lend = 1'b0;
        iaddr = 32'h4; maddr = 32'h0;
        push(0, 32'h0000_00AB); push(4, 32'h2); push(1, 32'h0403_0201);
        step();

        // Data port: old word in the write cycle, new word afterwards, aliased address wraps
        mwe = 1'b1; maddr = 32'hC; mdata = 32'h1111_1111;
        step();
        mdata = 32'hDEAD_BEEF;
        push(1, 32'h1111_1111);
        step();
        mwe = 1'b0;
        push(1, 32'hDEAD_BEEF);
        step();
        maddr = 32'h0000_100C;
        push(1, 32'hDEAD_BEEF); push(7, 32'hDEAD_BEEF);
        step();

        // Write lock during LOAD
        lstart = 1'b1;
        step();
        lstart = 1'b0;
        mwe = 1'b1; maddr = 32'h0; mdata = 32'hFFFF_FFFF;
        push(2, 32'h1);
        step();
        mwe = 1'b0;
        push(1, 32'h0403_0201); push(2, 32'h1); push(7, 32'h0403_0201);
        step();

        // Overflow of the 4-word instance with 17 bytes
        for (int i = 0; i < 17; i++) begin
            lvalid = 1'b1; ldata = 8'(8'h10 + i);
            step();
        end
        lvalid = 1'b0;
        push(10, 32'h4); push(11, 32'h1); push(4, 32'h4); push(5, 32'h0);
        for (int k = 0; k < 4; k++) begin
            maddr = 32'(4 * k);
            w = {8'(8'h13 + 4 * k), 8'(8'h12 + 4 * k), 8'(8'h11 + 4 * k), 8'(8'h10 + 4 * k)};
            push(7, w);
            step();
        end
        // Two more bytes leave the big instance mid-word, then reset
        lvalid = 1'b1; ldata = 8'h55;
        step();
        ldata = 8'h66;
        step();
        lvalid = 1'b0; rst = 1'b1;
        push(11, 32'h0); push(8, 32'h1); push(9, 32'h1); push(10, 32'h0);
        push(5, 32'h0); push(4, 32'h0); push(2, 32'h1);
        step();
        rst = 1'b0; maddr = 32'h0;
        push(7, 32'h1312_1110); push(1, 32'h1312_1110);
        step();

        // Randomized load/run episodes
        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(0, 24);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rand_bus();
                    step();
                end
                rand_bus();
                lvalid = 1'b1; ldata = 8'($urandom);
                lstart = ($urandom_range(0, 29) == 0);
                step();
                lvalid = 1'b0; lstart = 1'b0;
            end
            rand_bus();
            lend = 1'b1; lvalid = 1'($urandom_range(0, 1)); ldata = 8'($urandom);
            step();
            lend = 1'b0; lvalid = 1'b0;
            for (int j = 0; j < 30; j++) begin
                rand_bus();
                lvalid = 1'($urandom_range(0, 1)); ldata = 8'($urandom);
                lend = ($urandom_range(0, 9) == 0);
                step();
            end
            lvalid = 1'b0; lend = 1'b0;
            if (it % 7 == 3) begin
                mwe = 1'b0; rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                rand_bus();
                lstart = 1'b1;
                step();
                lstart = 1'b0;
            end
            mwe = 1'b0;
        end

        @(negedge clk);
        #1;
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
